// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: assembles two-byte pixels and writes whole frames to a linear frame buffer.
// Optional OV7670_CAPTURE_SKIP_EN: capture only every other camera frame.
module ov7670_capture #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [11:0]       frame_pixel,
  output logic              frame_we,
  output logic              frame_done,
  output logic              overflow,
  output logic [9:0]        line_count
);

  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(H_RES * V_RES);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;
  state_t state;

  logic        vs_q, vs_q2, hr_q, hr_q2;
  logic [7:0]  d_q;
  logic        phase;
  logic [3:0]  r;
  logic        pend;
  logic [11:0] pend_pix;
  logic        done_pend;
  logic [9:0]  lines;

  logic        vs_rise, vs_fall, hr_fall;
  logic        start;
  logic        room;
  logic [9:0]  lines_nx;

`ifdef OV7670_CAPTURE_SKIP_EN
  logic toggle;
`endif

  always_comb begin
    vs_rise  = vs_q & ~vs_q2;
    vs_fall  = ~vs_q & vs_q2;
    hr_fall  = ~hr_q & hr_q2;
    room     = {1'b0, frame_addr} < PIX_TOTAL;
    lines_nx = (hr_fall && lines != '1) ? lines + 10'd1 : lines;
`ifdef OV7670_CAPTURE_SKIP_EN
    start    = vs_fall & capture_en & ~toggle;
`else
    start    = vs_fall & capture_en;
`endif
  end

  // Completed pixels sit one cycle in pend so the write, its address and
  // frame_done all appear on the same registered stage.
  always_ff @(posedge pclk) begin
    if (!resetn) begin
      vs_q        <= 1'b0;
      vs_q2       <= 1'b0;
      hr_q        <= 1'b0;
      hr_q2       <= 1'b0;
      d_q         <= '0;
      state       <= IDLE;
      phase       <= 1'b0;
      r           <= '0;
      pend        <= 1'b0;
      pend_pix    <= '0;
      done_pend   <= 1'b0;
      lines       <= '0;
      frame_addr  <= '0;
      frame_pixel <= '0;
      frame_we    <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      line_count  <= '0;
`ifdef OV7670_CAPTURE_SKIP_EN
      toggle      <= 1'b0;
`endif
    end else begin
      vs_q  <= cam_vsync;
      vs_q2 <= vs_q;
      hr_q  <= cam_href;
      hr_q2 <= hr_q;
      d_q   <= cam_data;

      frame_we   <= 1'b0;
      frame_done <= done_pend;
      done_pend  <= 1'b0;
      pend       <= 1'b0;

      if (frame_we)
        frame_addr <= frame_addr + ADDR_W'(1);

      if (pend) begin
        frame_pixel <= pend_pix;
        if (room)
          frame_we <= 1'b1;
        else
          overflow <= 1'b1;
      end

`ifdef OV7670_CAPTURE_SKIP_EN
      if (vs_fall)
        toggle <= ~toggle;
`endif

      case (state)
        IDLE: begin
          if (vs_rise)
            state <= SYNC;
        end
        SYNC: begin
          if (start) begin
            state      <= ACTIVE;
            frame_addr <= '0;
            phase      <= 1'b0;
            overflow   <= 1'b0;
            lines      <= '0;
          end
        end
        ACTIVE: begin
          if (hr_q) begin
            if (!phase) begin
              r     <= d_q[3:0];
              phase <= 1'b1;
            end else begin
              pend     <= 1'b1;
              pend_pix <= {r, d_q};
              phase    <= 1'b0;
            end
          end else if (hr_fall) begin
            phase <= 1'b0;
          end
          lines <= lines_nx;
          if (vs_rise) begin
            done_pend  <= 1'b1;
            line_count <= lines_nx;
            state      <= SYNC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x2 frame: vector table plus latency/reset/skip sequences.
module tb_ov7670_capture;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          resetn;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          capture_en;
  logic [AW-1:0] frame_addr;
  logic [11:0]   frame_pixel;
  logic          frame_we;
  logic          frame_done;
  logic          overflow;
  logic [9:0]    line_count;

  int checks   = 0;
  int failures = 0;
  int nw = 0;
  int nd = 0;
  logic [AW-1:0] log_addr [256];
  logic [11:0]   log_pix  [256];

  ov7670_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .pclk        (pclk),
    .resetn      (resetn),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .capture_en  (capture_en),
    .frame_addr  (frame_addr),
    .frame_pixel (frame_pixel),
    .frame_we    (frame_we),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .line_count  (line_count)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (frame_we) begin
      if (nw < 256) begin
        log_addr[nw] = frame_addr;
        log_pix[nw]  = frame_pixel;
      end
      nw = nw + 1;
    end
    if (frame_done)
      nd = nd + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic vs_up();
    cam_vsync = 1'b1;
    tick(6);
  endtask

  task automatic vs_down();
    cam_vsync = 1'b0;
    tick(4);
  endtask

  task automatic send_line(input int len, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < len; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? b0 : b1;
      tick();
    end
    cam_href = 1'b0;
    cam_data = '0;
    tick(4);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"},  int'(frame_addr),  0);
    chk({tag, "_pixel"}, int'(frame_pixel), 0);
    chk({tag, "_we"},    int'(frame_we),    0);
    chk({tag, "_done"},  int'(frame_done),  0);
    chk({tag, "_ovf"},   int'(overflow),    0);
    chk({tag, "_lines"}, int'(line_count),  0);
  endtask

  typedef struct {
    logic        en;
    int          nlines;
    int          first_len;
    int          len;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          exp_w;
    int          exp_done;
    int          exp_lines;
    logic        exp_ovf;
    int          exp_addr;
    logic [11:0] exp_pix;
  } vec_t;

  vec_t tv [5];

  initial begin
    int w0, d0;

    tv[0] = '{1'b1, 2, 8, 8, 8'h0A, 8'hBC, 8, 1, 2, 1'b0, 8, 12'hABC};
    tv[1] = '{1'b1, 3, 8, 8, 8'h0A, 8'hBC, 8, 1, 3, 1'b1, 8, 12'hABC};
    tv[2] = '{1'b1, 2, 7, 8, 8'h0A, 8'hBC, 7, 1, 2, 1'b0, 7, 12'hABC};
    tv[3] = '{1'b0, 2, 8, 8, 8'h0A, 8'hBC, 0, 0, 2, 1'b0, 7, 12'hABC};
    tv[4] = '{1'b1, 2, 4, 4, 8'h05, 8'h3C, 4, 1, 2, 1'b0, 4, 12'h53C};

    resetn     = 1'b0;
    cam_vsync  = 1'b0;
    cam_href   = 1'b0;
    cam_data   = '0;
    capture_en = 1'b1;
    tick(3);
    @(negedge pclk);
    chk_reset_values("reset");
    tick();
    resetn = 1'b1;
    vs_up();

`ifdef OV7670_CAPTURE_SKIP_EN
    w0 = nw;
    d0 = nd;
    for (int f = 0; f < 4; f++) begin
      vs_down();
      send_line(4, 8'h0A, 8'hBC);
      vs_up();
    end
    chk("skip_done",  nd - d0, 2);
    chk("skip_writes", nw - w0, 4);
    chk("skip_lines", int'(line_count), 1);
    for (int i = 0; i < nw - w0 && i < 4; i++) begin
      chk($sformatf("skip_addr%0d", i), int'(log_addr[w0 + i]), i % 2);
      chk($sformatf("skip_pix%0d", i),  int'(log_pix[w0 + i]),  'hABC);
    end
`else
    for (int t = 0; t < 5; t++) begin
      capture_en = tv[t].en;
      vs_down();
      w0 = nw;
      d0 = nd;
      for (int l = 0; l < tv[t].nlines; l++)
        send_line((l == 0) ? tv[t].first_len : tv[t].len, tv[t].b0, tv[t].b1);
      vs_up();
      chk($sformatf("v%0d_writes", t), nw - w0, tv[t].exp_w);
      chk($sformatf("v%0d_done", t),   nd - d0, tv[t].exp_done);
      chk($sformatf("v%0d_lines", t),  int'(line_count), tv[t].exp_lines);
      chk($sformatf("v%0d_ovf", t),    int'(overflow),   int'(tv[t].exp_ovf));
      chk($sformatf("v%0d_addr_end", t), int'(frame_addr), tv[t].exp_addr);
      for (int i = 0; i < nw - w0 && i < tv[t].exp_w; i++) begin
        chk($sformatf("v%0d_addr%0d", t, i), int'(log_addr[w0 + i]), i);
        chk($sformatf("v%0d_pix%0d", t, i),  int'(log_pix[w0 + i]),  int'(tv[t].exp_pix));
      end
    end

    // Latency: second byte sampled at edge k, write visible after edge k+2.
    capture_en = 1'b1;
    vs_down();
    w0 = nw;
    d0 = nd;
    cam_href = 1'b1;
    cam_data = 8'h0A;
    tick();
    cam_data = 8'hBC;
    tick();
    cam_href = 1'b0;
    cam_data = '0;
    @(negedge pclk);
    chk("lat_k0_we", int'(frame_we), 0);
    tick();
    @(negedge pclk);
    chk("lat_k1_we", int'(frame_we), 0);
    tick();
    @(negedge pclk);
    chk("lat_k2_we",    int'(frame_we),    1);
    chk("lat_k2_pixel", int'(frame_pixel), 'hABC);
    chk("lat_k2_addr",  int'(frame_addr),  0);
    tick();
    @(negedge pclk);
    chk("lat_k3_we",   int'(frame_we),   0);
    chk("lat_k3_addr", int'(frame_addr), 1);
    tick(3);
    vs_up();
    chk("lat_writes", nw - w0, 1);
    chk("lat_done",   nd - d0, 1);
    chk("lat_lines",  int'(line_count), 1);

    // Reset in mid-line: rest of frame dropped, next full frame from address 0.
    vs_down();
    for (int i = 0; i < 5; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? 8'h0A : 8'hBC;
      tick();
    end
    resetn = 1'b0;
    tick(2);
    @(negedge pclk);
    chk_reset_values("midrst");
    tick();
    w0 = nw;
    d0 = nd;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cam_data = (i % 2 == 0) ? 8'hBC : 8'h0A;
      tick();
    end
    cam_href = 1'b0;
    cam_data = '0;
    tick(4);
    send_line(8, 8'h0A, 8'hBC);
    vs_up();
    chk("midrst_rest_writes", nw - w0, 0);
    chk("midrst_rest_done",   nd - d0, 0);
    vs_down();
    w0 = nw;
    d0 = nd;
    send_line(8, 8'h0A, 8'hBC);
    send_line(8, 8'h0A, 8'hBC);
    vs_up();
    chk("f2_writes", nw - w0, 8);
    chk("f2_done",   nd - d0, 1);
    chk("f2_lines",  int'(line_count), 2);
    if (nw - w0 >= 8) begin
      chk("f2_first_addr", int'(log_addr[w0]),     0);
      chk("f2_last_addr",  int'(log_addr[w0 + 7]), 7);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
